// File: rtl/registrador_8bits_ffd.sv
// 8-bit parallel-load register: eight rising-edge D cells sharing an active-low
// asynchronous clear (highest priority) and an active-low asynchronous preset.
module registrador_8bits_ffd (
    input  logic       clk,
    input  logic [7:0] d,
    input  logic       preset,
    input  logic       clear,
    output logic [7:0] q,
    output logic [7:0] qneg
);

    logic       setN;
    logic [7:0] state;

    // Preset is masked while clear is low, so releasing clear with preset
    // still low produces a falling edge on setN and the cells jump to all-ones
    // without waiting for a clock.
    assign setN = preset | ~clear;

    always_ff @(posedge clk or negedge clear or negedge setN) begin
        if (!clear) begin
            state <= 8'h00;
        end else if (!setN) begin
            state <= 8'hFF;
        end else begin
            state <= d;
        end
    end

    assign q    = state;
    assign qneg = ~state;

endmodule

// File: tb/tb_registrador_8bits_ffd.sv
// Self-checking bench for registrador_8bits_ffd: expected words are queued as
// stimulus is applied and popped when the outputs are sampled.
`timescale 1ns/1ps
module tb_registrador_8bits_ffd;

    logic       clk;
    logic [7:0] d;
    logic       preset;
    logic       clear;
    logic [7:0] q;
    logic [7:0] qneg;

    int testCount = 0;
    int failCount = 0;
    logic [7:0] expQueue[$];

    registrador_8bits_ffd dut (
        .clk   (clk),
        .d     (d),
        .preset(preset),
        .clear (clear),
        .q     (q),
        .qneg  (qneg)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
        end
    endtask

    task automatic pushExpected(input logic [7:0] value);
        expQueue.push_back(value);
    endtask

    // Pops the next expected word and checks q, qneg and the complement invariant.
    task automatic sampleAndCheck(input string tag);
        logic [7:0] expWord;
        if (expQueue.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL %s: scoreboard empty, got %h, want a queued value", tag, q);
        end else begin
            expWord = expQueue.pop_front();
            checkOutput({tag, ".q"}, q, expWord);
            checkOutput({tag, ".qneg"}, qneg, ~expWord);
            checkOutput({tag, ".inv"}, qneg ^ q, 8'hFF);
        end
    endtask

    // Drives d at the falling edge and checks the word loaded by the next rising edge.
    task automatic applyStimulus(input logic [7:0] newD, input logic [7:0] expQ, input string tag);
        @(negedge clk);
        d = newD;
        pushExpected(expQ);
        @(posedge clk);
        #1;
        sampleAndCheck(tag);
    endtask

    initial begin
        #20000;
        testCount++;
        failCount++;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        d      = 8'h00;
        preset = 1'b1;
        clear  = 1'b0;
        #1;
        pushExpected(8'h00);
        sampleAndCheck("reset_initial");

        // Clear held low while d toggles: output stays zero at edges and mid-cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 8'hFF : 8'h00, 8'h00, "reset_edge");
            #5;
            d = ~d;
            pushExpected(8'h00);
            sampleAndCheck("reset_mid");
        end

        @(negedge clk);
        #2;
        clear = 1'b1;
        d     = 8'h5A;
        #1;
        pushExpected(8'h00);
        sampleAndCheck("clear_release_hold");

        applyStimulus(8'h00, 8'h00, "load_00");
        applyStimulus(8'hFF, 8'hFF, "load_ff");
        #3;
        d = 8'h12;
        #2;
        d = 8'h34;
        #1;
        pushExpected(8'hFF);
        sampleAndCheck("glitch_ignored");
        applyStimulus(8'hAA, 8'hAA, "load_aa");

        #3;
        preset = 1'b0;
        #1;
        pushExpected(8'hFF);
        sampleAndCheck("preset_async");
        applyStimulus(8'h00, 8'hFF, "preset_hold_00");
        applyStimulus(8'hFF, 8'hFF, "preset_hold_ff");
        applyStimulus(8'h55, 8'hFF, "preset_hold_55");

        #3;
        clear = 1'b0;
        #1;
        pushExpected(8'h00);
        sampleAndCheck("both_low");
        clear = 1'b1;
        #1;
        pushExpected(8'hFF);
        sampleAndCheck("clear_release_preset_low");
        @(posedge clk);
        #1;
        pushExpected(8'hFF);
        sampleAndCheck("preset_still_low_edge");

        @(negedge clk);
        d = 8'h33;
        #2;
        preset = 1'b1;
        #1;
        pushExpected(8'hFF);
        sampleAndCheck("preset_release_hold");
        @(posedge clk);
        #1;
        pushExpected(8'h33);
        sampleAndCheck("preset_release_load");

        #4;
        clear = 1'b0;
        #1;
        pushExpected(8'h00);
        sampleAndCheck("clear_async");
        applyStimulus(8'hC3, 8'h00, "clear_hold");
        #3;
        clear = 1'b1;
        #1;
        pushExpected(8'h00);
        sampleAndCheck("clear_release_hold2");
        @(posedge clk);
        #1;
        pushExpected(8'hC3);
        sampleAndCheck("clear_release_load");
        applyStimulus(8'h0F, 8'h0F, "load_0f");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/registrador_8bits_ffd.md
# registrador_8bits_ffd

8-bit parallel-load register built from eight positive-edge D flip-flops, each with asynchronous preset and clear and complementary outputs. Used as a general storage stage in the datapath: captures an 8-bit word on every rising clock edge and offers both true (`q`) and inverted (`qneg`) outputs. Asynchronous clear is the block reset; asynchronous preset forces all bits to 1.

## Interface

Parameters:
- None. Width is fixed at 8 bits.

Ports, in the positional instantiation order `clk, d, preset, clear, q, qneg`:
- `clk` input, 1 bit. Single clock; all synchronous activity on its rising edge.
- `clear` input, 1 bit. Reset: asynchronous, active-low. `0` forces `q = 8'h00` immediately.
- `d` input, 8 bits. Data word captured on the rising edge of `clk`.
- `preset` input, 1 bit. Asynchronous, active-low. `0` forces `q = 8'hFF` immediately.
- `q` output, 8 bits. Stored word.
- `qneg` output, 8 bits. Bitwise complement of `q` at all times.

## Operation

- The block is eight identical 1-bit D flip-flop cells. Bit `i` uses `d[i]`, `q[i]` and `qneg[i]`. All cells share `clk`, `preset` and `clear`.
- Priority per cell, highest first:
  1. `clear == 0`: `q[i] = 0`. This holds regardless of `preset`, `clk` and `d`.
  2. `preset == 0` (with `clear == 1`): `q[i] = 1`.
  3. Otherwise, on a rising edge of `clk`: `q[i] <= d[i]`.
  4. Otherwise `q[i]` holds.
- Both asynchronous inputs low at the same time: clear wins. `q = 8'h00` and `qneg = 8'hFF`; `q` and `qneg` never equal each other.
- `qneg` is always `~q`. There is no state in which both outputs of a cell are 1 or both are 0.
- Reset value (`clear` low): `q = 8'h00`, `qneg = 8'hFF`.
- Preset value (`preset` low, `clear` high): `q = 8'hFF`, `qneg = 8'h00`.
- No enable input. With both asynchronous inputs high, every rising edge loads `d`.
- No arithmetic and no width conversion. Bit `i` maps straight to bit `i`.

## Timing

- Load latency: `q` shows the `d` value sampled at rising edge N immediately after edge N (zero-cycle register delay, one register stage). `qneg` updates in the same delta.
- `clear` and `preset` act asynchronously. Assertion changes `q`/`qneg` without waiting for a clock edge, and the forced value holds for as long as the input stays low.
- Deassertion mid-operation: after the last asynchronous input goes high, the register keeps the forced value until the next rising edge, which loads `d`.
  - If deassertion coincides with a rising edge, the forced value is kept for that edge. The first load is on the following edge.
  - Benches must deassert at least 1 ns away from a rising edge.
- Releasing `clear` while `preset` is still low switches `q` from `8'h00` to `8'hFF` asynchronously.
- `d` changes between rising edges have no effect on `q`.
- No handshake and no valid/ready signalling.

## Test plan

- Reset: `clear=0`, `preset=1`, `d` toggling `8'h00/8'hFF` over several 20 ns clock periods -> `q=8'h00` and `qneg=8'hFF` throughout, including mid-cycle.
- Normal load: `clear=1`, `preset=1`, apply `d=8'h00`, `8'hFF`, `8'hAA` one per clock.
  - After each rising edge: `q=8'h00` / `qneg=8'hFF`, then `q=8'hFF` / `qneg=8'h00`, then `q=8'hAA` / `qneg=8'h55`.
  - Mid-cycle `d` glitches do not change `q`.
- Preset: `clear=1`, assert `preset=0` between edges with `q=8'hAA` -> `q=8'hFF` and `qneg=8'h00` before the next edge. It holds while `d` cycles `8'h00`, `8'hFF`, `8'h55`.
- Simultaneous assertion: `preset=0`, `clear=0` -> `q=8'h00`, `qneg=8'hFF`. Then release `clear` only -> `q=8'hFF` asynchronously.
- Release then load: from the preset state, release `preset` mid-cycle with `d=8'h33` -> `q` stays `8'hFF` until the next rising edge, then becomes `8'h33` with `qneg=8'hCC`.
- Invariant check: on every time step of all scenarios, `qneg == ~q`.
